// File: rtl/mdio_phy_responder_if.sv
// MDIO pad bundle between a clause-22 management master and a PHY-side
// responder. The master owns MDC and presents the resolved pad value on
// mdio_in; the responder returns its drive value and output enable.
interface mdio_phy_responder_if;
  logic MDC;
  logic mdio_in;
  logic mdio_out;
  logic mdio_oe;

  modport master (
    output MDC,
    output mdio_in,
    input  mdio_out,
    input  mdio_oe
  );

  modport slave (
    input  MDC,
    input  mdio_in,
    output mdio_out,
    output mdio_oe
  );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder (PHY side) emulating a DP83848 register subset.
// MDC is oversampled in the clk_100Mz domain: MDC and mdio_in each pass a
// 2-FF synchronizer, and every protocol step happens on a detected rising
// edge of the synchronized MDC. Pad outputs move 3 system cycles after the
// MDC pin edge (2 synchronizer stages + 1 output register).
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'h01,
  parameter logic [15:0] BMCR_RST = 16'h3100
) (
  input  logic                  clk_100Mz,
  input  logic                  reset_N,
  mdio_phy_responder_if.slave   mdio,
  input  logic                  link_up,
  output logic                  wr_stb,
  output logic [4:0]            wr_addr,
  output logic [15:0]           wr_data,
  output logic                  rd_stb
);

  localparam logic [15:0] ANAR_RST = 16'h01E1;
  localparam logic [5:0]  PRE_LEN  = 6'd32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST2   = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6,
    S_SKIP  = 3'd7
  } state_t;

  // Synchronizer and edge-detect registers
  logic        r_mdc_s1;
  logic        r_mdc_s2;
  logic        r_mdc_d;
  logic        r_mdi_s1;
  logic        r_mdi_s2;

  // Protocol state
  state_t      r_state;
  logic [5:0]  r_pre_cnt;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_shift;
  logic        r_is_read;
  logic [4:0]  r_phyad;
  logic [4:0]  r_regad;

  // Writable registers
  logic [15:0] r_bmcr;
  logic [15:0] r_anar;

  // Registered outputs
  logic        r_mdio_out;
  logic        r_mdio_oe;
  logic        r_wr_stb;
  logic [4:0]  r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_rd_stb;

  logic        w_rise;
  logic        w_mdi;
  logic [15:0] w_shift_in;

  // Read-side register map; status bits track link_up live.
  function automatic logic [15:0] f_reg_read(
    input logic [4:0]  addr,
    input logic [15:0] bmcr,
    input logic [15:0] anar,
    input logic        link
  );
    logic [15:0] val;
    case (addr)
      5'h00:   val = bmcr;
      5'h01:   val = 16'h7849 | {13'h0000, link, 2'b00};
      5'h02:   val = 16'h2000;
      5'h03:   val = 16'h5C90;
      5'h04:   val = anar;
      5'h10:   val = {15'h0000, link};
      default: val = 16'h0000;
    endcase
    return val;
  endfunction

  assign w_rise     = r_mdc_s2 & ~r_mdc_d;
  assign w_mdi      = r_mdi_s2;
  assign w_shift_in = {r_shift[14:0], w_mdi};

  assign mdio.mdio_out = r_mdio_out;
  assign mdio.mdio_oe  = r_mdio_oe;
  assign wr_stb        = r_wr_stb;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign rd_stb        = r_rd_stb;

  // Bring MDC and MDIO into the system domain and keep a delayed MDC for edge detection
  always_ff @(posedge clk_100Mz or negedge reset_N) begin
    if (!reset_N) begin
      r_mdc_s1 <= 1'b0;
      r_mdc_s2 <= 1'b0;
      r_mdc_d  <= 1'b0;
      r_mdi_s1 <= 1'b0;
      r_mdi_s2 <= 1'b0;
    end else begin
      r_mdc_s1 <= mdio.MDC;
      r_mdc_s2 <= r_mdc_s1;
      r_mdc_d  <= r_mdc_s2;
      r_mdi_s1 <= mdio.mdio_in;
      r_mdi_s2 <= r_mdi_s1;
    end
  end

  // Frame FSM: preamble, start, opcode, addresses, turnaround, data, register commit
  always_ff @(posedge clk_100Mz or negedge reset_N) begin
    if (!reset_N) begin
      r_state    <= S_IDLE;
      r_pre_cnt  <= 6'd0;
      r_bit_cnt  <= 5'd0;
      r_shift    <= 16'h0000;
      r_is_read  <= 1'b0;
      r_phyad    <= 5'h00;
      r_regad    <= 5'h00;
      r_bmcr     <= BMCR_RST;
      r_anar     <= ANAR_RST;
      r_mdio_out <= 1'b0;
      r_mdio_oe  <= 1'b0;
      r_wr_stb   <= 1'b0;
      r_wr_addr  <= 5'h00;
      r_wr_data  <= 16'h0000;
      r_rd_stb   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_wr_stb <= 1'b0;
      r_rd_stb <= 1'b0;
      if (w_rise) begin
        case (r_state)
          S_IDLE: begin
            // Saturating count of consecutive ones; a zero only starts a
            // frame once a full preamble has been seen.
            if (w_mdi) begin
              if (r_pre_cnt != PRE_LEN) begin
                r_pre_cnt <= r_pre_cnt + 6'd1;
              end
            end else if (r_pre_cnt == PRE_LEN) begin
              r_pre_cnt <= 6'd0;
              r_state   <= S_ST2;
            end else begin
              r_pre_cnt <= 6'd0;
            end
          end

          S_ST2: begin
            if (w_mdi) begin
              r_bit_cnt <= 5'd0;
              r_state   <= S_OP;
            end else begin
              r_state <= S_IDLE;
            end
          end

          S_OP: begin
            r_shift <= w_shift_in;
            if (r_bit_cnt == 5'd1) begin
              r_bit_cnt <= 5'd0;
              case ({r_shift[0], w_mdi})
                2'b10: begin
                  r_is_read <= 1'b1;
                  r_state   <= S_PHYAD;
                end
                2'b01: begin
                  r_is_read <= 1'b0;
                  r_state   <= S_PHYAD;
                end
                default: r_state <= S_IDLE;
              endcase
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          S_PHYAD: begin
            r_shift <= w_shift_in;
            if (r_bit_cnt == 5'd4) begin
              r_phyad   <= w_shift_in[4:0];
              r_bit_cnt <= 5'd0;
              r_state   <= S_REGAD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          S_REGAD: begin
            // The pad stays released on this edge; a matching read only
            // starts driving on the following one.
            r_shift <= w_shift_in;
            if (r_bit_cnt == 5'd4) begin
              r_regad   <= w_shift_in[4:0];
              r_bit_cnt <= 5'd0;
              if (r_phyad == PHY_ADDR) begin
                r_state <= S_TA;
              end else begin
                r_state <= S_SKIP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          S_TA: begin
            if (r_is_read) begin
              // Second half of turnaround: drive 0 and snapshot the register
              // so later changes cannot disturb the frame in flight.
              r_mdio_oe  <= 1'b1;
              r_mdio_out <= 1'b0;
              r_rd_stb   <= 1'b1;
              r_shift    <= f_reg_read(r_regad, r_bmcr, r_anar, link_up);
              r_bit_cnt  <= 5'd0;
              r_state    <= S_DATA;
            end else begin
              r_shift <= w_shift_in;
              if (r_bit_cnt == 5'd1) begin
                r_bit_cnt <= 5'd0;
                if ({r_shift[0], w_mdi} == 2'b10) begin
                  r_state <= S_DATA;
                end else begin
                  r_state <= S_IDLE;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          S_DATA: begin
            if (r_is_read) begin
              if (r_bit_cnt == 5'd16) begin
                // Bit 0 has had its full MDC period; release the pad.
                r_mdio_oe  <= 1'b0;
                r_mdio_out <= 1'b0;
                r_bit_cnt  <= 5'd0;
                r_state    <= S_IDLE;
              end else begin
                r_mdio_out <= r_shift[15];
                r_shift    <= {r_shift[14:0], 1'b0};
                r_bit_cnt  <= r_bit_cnt + 5'd1;
              end
            end else begin
              r_shift <= w_shift_in;
              if (r_bit_cnt == 5'd15) begin
                r_bit_cnt <= 5'd0;
                r_state   <= S_IDLE;
                case (r_regad)
                  5'h00: begin
                    // Self-clearing soft reset bit restores the idle value.
                    if (w_shift_in[15]) begin
                      r_bmcr <= BMCR_RST & 16'h7FFF;
                    end else begin
                      r_bmcr <= w_shift_in;
                    end
                    r_wr_stb  <= 1'b1;
                    r_wr_addr <= r_regad;
                    r_wr_data <= w_shift_in;
                  end
                  5'h04: begin
                    r_anar    <= w_shift_in;
                    r_wr_stb  <= 1'b1;
                    r_wr_addr <= r_regad;
                    r_wr_data <= w_shift_in;
                  end
                  default: begin
                    // Read-only or unimplemented: silently dropped.
                    r_wr_stb <= 1'b0;
                  end
                endcase
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          S_SKIP: begin
            // Another PHY's frame: let the TA and data bits pass untouched.
            if (r_bit_cnt == 5'd17) begin
              r_bit_cnt <= 5'd0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          default: begin
            r_state    <= S_IDLE;
            r_pre_cnt  <= 6'd0;
            r_bit_cnt  <= 5'd0;
            r_mdio_oe  <= 1'b0;
            r_mdio_out <= 1'b0;
          end
        endcase
      end else begin
        // No MDC edge: hold every piece of frame state.
        r_state <= r_state;
      end
    end
  end

endmodule

// File: doc/mdio_phy_responder.md
# mdio_phy_responder

Management-interface responder implementing the PHY end of the IEEE 802.3 clause-22 MDIO/MDC protocol. It answers the read/write frames our MDIO management master issues to the DP83848, for bench emulation and board loopback. It holds a small DP83848-compatible register set and reports write activity to surrounding logic. It runs entirely in the `clk_100Mz` domain and oversamples the manager's MDC.

## Interface
- `PHY_ADDR`, default 5'h01: PHY address this responder answers to.
- `BMCR_RST`, default 16'h3100: reset/idle value of register 0x00.
- `clk_100Mz`  in  1: system clock; the only clock.
- `reset_N`  in  1: asynchronous, active-low reset.
- `MDC`  in  1: management clock from the manager; asynchronous to `clk_100Mz`.
- `mdio_in`  in  1: MDIO pad input.
- `mdio_out`  out  1: MDIO pad output value.
- `mdio_oe`  out  1: MDIO output enable; 1 means the responder drives the pad.
- `link_up`  in  1: live link indication reflected into the status registers.
- `wr_stb`  out  1: one-cycle pulse when a write frame to an implemented register completes.
- `wr_addr`  out  5: register address of the last write.
- `wr_data`  out  16: data of the last write.
- `rd_stb`  out  1: one-cycle pulse when a read frame to this `PHY_ADDR` is accepted, at the end of TA.

## Operation
- MDC passes through a 2-FF synchronizer, then a rising-edge detector. Every protocol event happens on a detected rising edge (`rise`). `mdio_in` is synchronized the same way and sampled on `rise`.
- Registers:
  - 0x00 BMCR: writable. If a write sets bit 15, the register returns to `BMCR_RST` and bit 15 reads 0.
  - 0x01 BMSR: read-only, 16'h7849 with bit 2 = `link_up`.
  - 0x02: read-only, 16'h2000.
  - 0x03: read-only, 16'h5C90.
  - 0x04 ANAR: writable, reset 16'h01E1.
  - 0x10 PHYSTS: read-only, 16'h0000 with bit 0 = `link_up`.
  - All other addresses read 16'h0000. Writes to them are ignored and give no `wr_stb`.
  - Writes to read-only registers are ignored and give no `wr_stb`.
- FSM states:
  - IDLE: a saturating preamble counter counts consecutive sampled 1s, up to 32. A sampled 0 with count = 32 moves to ST2. A sampled 0 with count < 32 clears the counter and stays in IDLE.
  - ST2: expects 1. If it samples 0, go to IDLE with the counter cleared.
  - OP: 2 bits. 10 = read, 01 = write. 00 or 11 go to IDLE.
  - PHYAD: 5 bits, MSB first. REGAD: 5 bits, MSB first.
  - TA:
    - Read, address match: on the `rise` that samples the last REGAD bit, keep `mdio_oe` = 0. On the next `rise`, set `mdio_oe` = 1, `mdio_out` = 0, and pulse `rd_stb`. The read data is latched from the register at this point.
    - Write: sample both TA bits. A value other than 10 aborts to IDLE.
  - DATA: 16 bits, MSB first.
    - Read: on each following `rise`, drive the next bit (bit 15 first). On the `rise` after bit 0 was driven, set `mdio_oe` = 0 and go to IDLE.
    - Write: shift in 16 bits. On the 16th sample, commit the register and pulse `wr_stb` with `wr_addr`/`wr_data` updated the same cycle. Then go to IDLE.
- PHYAD ≠ `PHY_ADDR`: never drive the pad. Count the remaining 18 bits (TA + DATA) passively, then go to IDLE.
- After any return to IDLE, the preamble counter restarts at 0. Back-to-back frames each need a fresh 32-bit preamble.
- Read and write frames never overlap, so register state cannot conflict between them.

## Timing
- Reset values: `mdio_oe` = 0, `mdio_out` = 0, `wr_stb` = 0, `rd_stb` = 0, `wr_addr` = 0, `wr_data` = 0, FSM = IDLE, preamble counter = 0, BMCR = `BMCR_RST`, ANAR = 16'h01E1.
- Pin-to-event latency: `mdio_out`/`mdio_oe` change exactly 3 `clk_100Mz` cycles after the MDC rising edge at the pin (2 synchronizer cycles + 1 register cycle). This is 30 ns, well inside the 300 ns clause-22 limit.
- MDC high and low phases must each be ≥ 4 `clk_100Mz` cycles, i.e. MDC ≤ 12.5 MHz. The default 2.5 MHz MDC has ample margin.
- Read data is sampled from the register at the second TA edge. Register changes after that point do not affect the frame in flight. `link_up` changes after that point are likewise not reflected in the frame.
- Asserting `reset_N` mid-frame immediately forces `mdio_oe` = 0, with no MDC edge needed. The next frame requires a full preamble.
- MDC stopping mid-frame holds all state indefinitely. Nothing times out.

## Test plan
- Read BMCR with `PHY_ADDR` matching, after reset, at 2.5 MHz MDC: 32×1, 01, 10, 00001, 00000 → TA reads Z then 0, then data 16'h3100 MSB first. `rd_stb` pulses once. `mdio_oe` falls 3 cycles after the rising edge following bit 0.
- Write ANAR with 16'h05E1, then read it back: `wr_stb` pulses once with `wr_addr` = 5'h04 and `wr_data` = 16'h05E1. The readback returns 16'h05E1.
- Write BMCR with 16'hB100: `wr_stb` pulses. A subsequent read returns 16'h3100.
- Read BMSR and PHYSTS with `link_up` = 1: they return 16'h784D and 16'h0001. With `link_up` = 0: they return 16'h7849 and 16'h0000.
- Negative cases:
  - Preamble of only 31 ones: no response.
  - OP 11: no response.
  - PHYAD 5'h02: `mdio_oe` stays 0 for the whole frame.
  - Write with TA 11: no `wr_stb`, register unchanged.
  - Write to 0x02: no `wr_stb`, still reads 16'h2000.
- Reset mid-read: assert `reset_N` during data bit 7 → `mdio_oe` = 0 asynchronously. The next full read frame succeeds.
